// File: rtl/wb_mtimer.sv
// wb_mtimer: Wishbone B4 slave, RISC-V style 64-bit mtime/mtimecmp with prescaler and level IRQ.
// Optional WB_MTIMER_SNAPSHOT_EN: an MTIME_LO read latches mtime[63:32] for a tear-free MTIME_HI read.
module wb_mtimer #(
  parameter int          PRESCALE_W   = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_O,
  output logic [31:0] DAT_I,
  output logic        ACK,
  output logic        ERR,
  output logic        timer_irq
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;
  localparam logic [2:0] A_PRESCALE = 3'd5;

  typedef enum logic {IDLE, RESP} state_e;

  typedef struct packed {
    logic        vld;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } req_t;

  state_e                state_q, state_d;
  logic                  ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]           dat_q, dat_d;
  logic [63:0]           mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic                  en_q, en_d, irq_en_q, irq_en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, pcnt_q, pcnt_d;

  req_t        req;
  logic        mapped, tick;
  logic [31:0] rdata, mtime_hi_rd;
  logic        unused_adr;

  assign unused_adr = ^{ADR[31:5], ADR[1:0]};

`ifdef WB_MTIMER_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;
  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    req    = '{vld: (state_q == IDLE) && CYC && STB, we: WE, sel: ADR[4:2], wdata: DAT_O};
    mapped = (req.sel <= A_PRESCALE);
    tick   = en_q && (pcnt_q == prescale_q);
    rdata  = '0;
    case (req.sel)
      A_MTIME_LO: rdata = mtime_q[31:0];
      A_MTIME_HI: rdata = mtime_hi_rd;
      A_CMP_LO:   rdata = mtimecmp_q[31:0];
      A_CMP_HI:   rdata = mtimecmp_q[63:32];
      A_CTRL:     rdata = {30'd0, irq_en_q, en_q};
      A_PRESCALE: rdata = 32'(prescale_q);
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = dat_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
`ifdef WB_MTIMER_SNAPSHOT_EN
    shadow_d   = shadow_q;
`endif
    // compare uses pre-edge values, so the IRQ lags the condition by one cycle
    irq_d      = irq_en_q && (mtime_q >= mtimecmp_q);

    if (tick) begin
      pcnt_d  = '0;
      mtime_d = mtime_q + 64'd1;
    end else if (en_q) begin
      pcnt_d  = pcnt_q + PRESCALE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (req.vld) begin
          state_d = RESP;
          ack_d   = mapped;
          err_d   = !mapped;
          if (!req.we) begin
            dat_d = rdata;
`ifdef WB_MTIMER_SNAPSHOT_EN
            if (req.sel == A_MTIME_LO) shadow_d = mtime_q[63:32];
`endif
          end else begin
            // an mtime write built from mtime_q discards any tick on this edge
            case (req.sel)
              A_MTIME_LO: mtime_d    = {mtime_q[63:32], req.wdata};
              A_MTIME_HI: mtime_d    = {req.wdata, mtime_q[31:0]};
              A_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], req.wdata};
              A_CMP_HI:   mtimecmp_d = {req.wdata, mtimecmp_q[31:0]};
              A_CTRL: begin
                en_d     = req.wdata[0];
                irq_en_d = req.wdata[1];
                pcnt_d   = '0;
              end
              A_PRESCALE: begin
                prescale_d = req.wdata[PRESCALE_W-1:0];
                pcnt_d     = '0;
              end
              default: ;
            endcase
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMECMP_RST;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      irq_q      <= 1'b0;
`ifdef WB_MTIMER_SNAPSHOT_EN
      shadow_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      irq_q      <= irq_d;
`ifdef WB_MTIMER_SNAPSHOT_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign DAT_I     = dat_q;
  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign timer_irq = irq_q;

endmodule

// File: tb/tb_wb_mtimer.sv
// Directed self-checking bench for wb_mtimer: bus handshake, prescaler, carry, IRQ, errors, snapshot.
module tb_wb_mtimer;
  logic        clk = 1'b0;
  logic        rst, CYC, STB, WE;
  logic [31:0] ADR, DAT_O, DAT_I;
  logic        ACK, ERR, timer_irq;

  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  int          acc = 0;
  int          e = 0;
  logic [31:0] rd;
  logic        ack, err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_mtimer dut (
    .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
    .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK(ACK), .ERR(ERR), .timer_irq(timer_irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // acc = index of the edge that performed the access
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_O = wd;
    @(posedge clk);
    @(negedge clk);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    rd = DAT_I; ack = ACK; err = ERR; acc = cyc;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
    bus(1'b1, adr, wd);
  endtask

  task automatic rdr(input logic [31:0] adr);
    bus(1'b0, adr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h0; DAT_O = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", ACK, 0);
    chk("rst_err", ERR, 0);
    chk("rst_irq", timer_irq, 0);
    chk("rst_dat", DAT_I, 0);
    rst = 1'b1; CYC = 1'b0; STB = 1'b0;

    rdr(32'h08);
    chk("cmp_lo_rst_ack", ack, 1);
    chk("cmp_lo_rst_err", err, 0);
    chk("cmp_lo_rst_val", rd, 32'hFFFF_FFFF);

    // PRESCALE=3: one tick every 4 edges after EN rises
    wr(32'h14, 32'd3);
    wr(32'h10, 32'd1);
    e = acc;
    repeat (40) @(negedge clk);
    rdr(32'h00);
    chk("presc3_lo", rd, 64'((acc - 1 - e) / 4));

    // PRESCALE=0: +1 per edge
    wr(32'h10, 32'd0);
    wr(32'h00, 32'd100);
    wr(32'h04, 32'd0);
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd1);
    e = acc;
    repeat (5) @(negedge clk);
    rdr(32'h00);
    chk("presc0_a", rd, 64'(100 + acc - 1 - e));
    rdr(32'h00);
    chk("presc0_b", rd, 64'(100 + acc - 1 - e));

    // MTIME_LO write on a tick edge: write wins, tick dropped
    wr(32'h00, 32'd50);
    e = acc;
    rdr(32'h00);
    chk("lo_wr_tick_drop", rd, 64'(50 + acc - 1 - e));
    rdr(32'h04);
    chk("hi_after_lo_wr", rd, 0);

    wr(32'h10, 32'd0);
    wr(32'h14, 32'hFFFF_1234);
    rdr(32'h14);
    chk("presc_width", rd, 32'h0000_1234);

    // carry/wrap: two ticks from FFFF_FFFF_FFFF_FFFE, then freeze
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h00, 32'hFFFF_FFFE);
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd1);
    wr(32'h10, 32'd0);
    rdr(32'h00);
    chk("wrap_lo", rd, 0);
    rdr(32'h04);
    chk("wrap_hi", rd, 0);

    // IRQ at mtimecmp=20; upper CTRL bits ignored
    wr(32'h0C, 32'd0);
    wr(32'h08, 32'd20);
    wr(32'h00, 32'd0);
    wr(32'h10, 32'hFFFF_FFFF);
    e = acc;
    chk("irq_off_start", timer_irq, 0);
    repeat (20) @(negedge clk);
    chk("irq_before", timer_irq, 0);
    @(negedge clk);
    chk("irq_rise", timer_irq, 1);
    wr(32'h08, 32'd1000);
    chk("irq_write_edge", timer_irq, 1);
    @(negedge clk);
    chk("irq_drop", timer_irq, 0);

    rdr(32'h08);
    chk("cmp_lo_1000", rd, 32'd1000);
    rdr(32'h18);
    chk("unmapped_rd_err", err, 1);
    chk("unmapped_rd_ack", ack, 0);
    chk("unmapped_rd_dat", rd, 0);
    @(negedge clk);
    chk("err_one_cycle", ERR, 0);
    wr(32'h1C, 32'd0);
    chk("unmapped_wr_err", err, 1);
    rdr(32'h10);
    chk("ctrl_bits", rd, 32'd3);

    // request held high for 6 cycles on CTRL
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h10;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("hs_ack", ACK, 64'(i % 2));
      chk("hs_err", ERR, 0);
    end
    chk("hs_dat", DAT_I, 32'd3);
    CYC = 1'b0; STB = 1'b0;

    // snapshot: HI read after the LO->HI carry
    wr(32'h10, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'hFFFF_FFF0);
    wr(32'h14, 32'd0);
    wr(32'h10, 32'd1);
    e = acc;
    rdr(32'h00);
    chk("snap_lo", rd, 64'(32'hFFFF_FFF0 + 32'(acc - 1 - e)));
    repeat (20) @(negedge clk);
    rdr(32'h04);
`ifdef WB_MTIMER_SNAPSHOT_EN
    chk("snap_hi", rd, 0);
`else
    chk("snap_hi", rd, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
